// File: rtl/l2_ic_responder_if.sv
// l2_ic_responder_if: icache request/response and memory beat port bundle.
// master = icache + memory side, slave = responder.
interface l2_ic_responder_if;
  logic         irq;
  logic [27:0]  l2_addr;
  logic         l2_cache_rw;
  logic         ic_rw_en;
  logic         buf_inv;
  logic         l2_busy;
  logic         l2_rdy;
  logic [127:0] data_wd_l2;
  logic         complete;
  logic         rw_err;
  logic         mem_req;
  logic [29:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;

  modport master (
    output irq, l2_addr, l2_cache_rw,
    output ic_rw_en, buf_inv,
    output mem_ack, mem_rdata,
    input  l2_busy, l2_rdy, data_wd_l2,
    input  complete, rw_err,
    input  mem_req, mem_addr
  );

  modport slave (
    input  irq, l2_addr, l2_cache_rw,
    input  ic_rw_en, buf_inv,
    input  mem_ack, mem_rdata,
    output l2_busy, l2_rdy, data_wd_l2,
    output complete, rw_err,
    output mem_req, mem_addr
  );
endinterface

// File: rtl/l2_ic_responder.sv
// l2_ic_responder: fetches a 128-bit icache refill block in four 32-bit beats.
// Define ICRESP_BLOCK_BUFFER_EN for a one-entry last-block buffer.
module l2_ic_responder (
  input  logic clk,
  input  logic rst,
  l2_ic_responder_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP,
    CMPL
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [27:0]  blk_addr_q;
  logic [1:0]   beat_q;
  logic [127:0] fill_q;
  logic         mem_req_q;
  logic         rd_req;
  logic         last_ack;
  logic         hit;
  logic         unused_in;

  assign rd_req   = bus.irq & ~bus.l2_cache_rw;
  assign last_ack = bus.mem_ack & (beat_q == 2'd3);

`ifdef ICRESP_BLOCK_BUFFER_EN
  logic buf_vld_q;

  // blk_addr_q doubles as the tag: it only moves on a new fill
  assign hit = buf_vld_q & ~bus.buf_inv &
               (bus.l2_addr == blk_addr_q);

  always_ff @(posedge clk) begin
    if (rst)
      buf_vld_q <= 1'b0;
    else if (state_q == FETCH && last_ack)
      buf_vld_q <= 1'b1;
    else if (bus.buf_inv)
      buf_vld_q <= 1'b0;
  end

  assign unused_in = bus.ic_rw_en;
`else
  assign hit       = 1'b0;
  assign unused_in = bus.ic_rw_en ^ bus.buf_inv;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rd_req)
          state_d = hit ? RESP : FETCH;
      end
      FETCH: begin
        if (last_ack)
          state_d = RESP;
      end
      RESP:    state_d = CMPL;
      CMPL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_addr_q <= '0;
      beat_q     <= '0;
      fill_q     <= '0;
      mem_req_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && rd_req) begin
        blk_addr_q <= bus.l2_addr;
        beat_q     <= '0;
        mem_req_q  <= ~hit;
      end
      // beat wraps 3->0 exactly on the last ack
      if (state_q == FETCH && bus.mem_ack) begin
        fill_q[{beat_q, 5'd0} +: 32] <= bus.mem_rdata;
        beat_q <= beat_q + 2'd1;
        if (beat_q == 2'd3)
          mem_req_q <= 1'b0;
      end
    end
  end

  assign bus.l2_busy    = (state_q != IDLE);
  assign bus.l2_rdy     = (state_q == RESP);
  assign bus.complete   = (state_q == CMPL);
  assign bus.rw_err     = (state_q == IDLE) &
                          bus.irq & bus.l2_cache_rw;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = {blk_addr_q, beat_q};
  assign bus.data_wd_l2 = fill_q;
endmodule

// File: tb/tb_l2_ic_responder.sv
// tb_l2_ic_responder: random refill traffic vs. a cycle-count/memory model.
// Buffer expectations follow ICRESP_BLOCK_BUFFER_EN when defined.
module tb_l2_ic_responder;
  logic clk = 1'b0;
  logic rst;

  l2_ic_responder_if bus ();

  l2_ic_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef ICRESP_BLOCK_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mem_m [logic [29:0]];
  int          wait_cfg [4];
  bit          buf_vld_m;
  logic [27:0] buf_tag_m;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (!mem_m.exists(a))
      mem_m[a] = $urandom;
    return mem_m[a];
  endfunction

  function automatic logic [127:0] exp_block(input logic [27:0] a);
    return {mem_word({a, 2'd3}), mem_word({a, 2'd2}),
            mem_word({a, 2'd1}), mem_word({a, 2'd0})};
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.l2_rdy === 1'b1 || bus.complete === 1'b1)) begin
      n_chk++;
      if (bus.ic_rw_en !== 1'b1) begin
        n_fail++;
        $display("FAIL ic_rw_en window: got %b need 1 (rdy=%b cmpl=%b)",
                 bus.ic_rw_en, bus.l2_rdy, bus.complete);
      end
    end
  end

  // One full request; expectations come from wait counts and the memory model.
  task automatic do_txn(input logic [27:0] a, input bit inv, input string nm);
    bit           hit;
    int           exp_rdy;
    int           exp_beats;
    logic [127:0] exp_blk;
    logic [127:0] got_blk;
    int cyc, beat, wcnt, rdy_cyc, cmpl_cyc;
    int n_rdy, n_cmpl, bad_addr, busy_bad, hold_bad;

    hit       = BUF_EN && buf_vld_m && (buf_tag_m == a) && !inv;
    exp_beats = hit ? 0 : 4;
    exp_rdy   = 1;
    if (!hit)
      for (int k = 0; k < 4; k++)
        exp_rdy += wait_cfg[k] + 1;
    exp_blk = exp_block(a);
    if (inv)
      buf_vld_m = 1'b0;
    if (!hit) begin
      buf_vld_m = 1'b1;
      buf_tag_m = a;
    end

    bus.irq         = 1'b1;
    bus.ic_rw_en    = 1'b1;
    bus.l2_cache_rw = 1'b0;
    bus.l2_addr     = a;
    bus.buf_inv     = inv;
    bus.mem_ack     = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.l2_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_c0: got %b need 0", nm, bus.l2_busy);
    end
    @(posedge clk);
    #1;
    bus.buf_inv = 1'b0;

    cyc = 1; beat = 0; wcnt = 0;
    rdy_cyc = -1; cmpl_cyc = -1;
    n_rdy = 0; n_cmpl = 0;
    bad_addr = 0; busy_bad = 0; hold_bad = 0;
    got_blk = '0;
    while (cmpl_cyc < 0 && cyc < 150) begin
      bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1) begin
        if (beat > 3 || bus.mem_addr !== {a, beat[1:0]})
          bad_addr++;
        if (beat > 3 || wcnt == wait_cfg[beat]) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = (beat <= 3) ? mem_word({a, beat[1:0]}) : $urandom;
          beat++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      @(negedge clk);
      if (bus.l2_busy !== 1'b1)
        busy_bad++;
      if (bus.l2_rdy === 1'b1) begin
        n_rdy++;
        rdy_cyc = cyc;
        got_blk = bus.data_wd_l2;
      end
      if (bus.complete === 1'b1) begin
        n_cmpl++;
        cmpl_cyc = cyc;
        if (bus.data_wd_l2 !== got_blk)
          hold_bad++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.irq      = 1'b0;
    bus.ic_rw_en = 1'b0;
    bus.mem_ack  = 1'b0;

    n_chk++;
    if (rdy_cyc != exp_rdy) begin
      n_fail++;
      $display("FAIL %s rdy_cycle: got %0d need %0d", nm, rdy_cyc, exp_rdy);
    end
    n_chk++;
    if (cmpl_cyc != exp_rdy + 1) begin
      n_fail++;
      $display("FAIL %s cmpl_cycle: got %0d need %0d", nm, cmpl_cyc, exp_rdy + 1);
    end
    n_chk++;
    if (n_rdy != 1 || n_cmpl != 1) begin
      n_fail++;
      $display("FAIL %s pulses: got rdy=%0d cmpl=%0d need 1/1", nm, n_rdy, n_cmpl);
    end
    n_chk++;
    if (got_blk !== exp_blk) begin
      n_fail++;
      $display("FAIL %s data: got %h need %h", nm, got_blk, exp_blk);
    end
    n_chk++;
    if (beat != exp_beats || bad_addr != 0) begin
      n_fail++;
      $display("FAIL %s beats: got %0d (bad addr %0d) need %0d (bad 0)",
               nm, beat, bad_addr, exp_beats);
    end
    n_chk++;
    if (busy_bad != 0 || hold_bad != 0) begin
      n_fail++;
      $display("FAIL %s busy/hold: got %0d/%0d bad cycles need 0/0",
               nm, busy_bad, hold_bad);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.irq         = 1'b0;
    bus.l2_addr     = '0;
    bus.l2_cache_rw = 1'b0;
    bus.ic_rw_en    = 1'b0;
    bus.buf_inv     = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    idle_cycles(3);
    @(negedge clk);
    n_chk++;
    if ({bus.l2_busy, bus.l2_rdy, bus.complete, bus.rw_err, bus.mem_req} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset ctl: got %b need 00000",
               {bus.l2_busy, bus.l2_rdy, bus.complete, bus.rw_err, bus.mem_req});
    end
    n_chk++;
    if (bus.mem_addr !== 30'd0 || bus.data_wd_l2 !== 128'd0) begin
      n_fail++;
      $display("FAIL reset data: got addr %h data %h need 0/0",
               bus.mem_addr, bus.data_wd_l2);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    buf_vld_m = 1'b0;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) begin
      mem_m[{28'h0000123, k[1:0]}] = 32'h11111111 * (k + 1);
      wait_cfg[k] = 0;
    end
    do_txn(28'h0000123, 1'b0, "basic");
    idle_cycles(1);
  endtask

  task automatic test_wait_states();
    for (int k = 0; k < 4; k++)
      wait_cfg[k] = 2;
    do_txn(28'h0000123, 1'b1, "wait2");
    idle_cycles(2);
  endtask

  task automatic test_rw_err();
    bus.irq         = 1'b1;
    bus.l2_cache_rw = 1'b1;
    bus.l2_addr     = 28'($urandom);
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if ({bus.rw_err, bus.l2_busy, bus.mem_req, bus.l2_rdy, bus.complete} !== 5'b10000) begin
        n_fail++;
        $display("FAIL rw_err: got err/busy/req/rdy/cmpl=%b need 10000",
                 {bus.rw_err, bus.l2_busy, bus.mem_req, bus.l2_rdy, bus.complete});
      end
      @(posedge clk);
      #1;
    end
    bus.irq         = 1'b0;
    bus.l2_cache_rw = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.rw_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_err_clear: got %b need 0", bus.rw_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [27:0] a;
    a = 28'h0ABCDEF;
    for (int k = 0; k < 4; k++)
      wait_cfg[k] = 0;
    bus.irq      = 1'b1;
    bus.ic_rw_en = 1'b1;
    bus.l2_addr  = a;
    bus.mem_ack  = 1'b0;
    idle_cycles(1);
    for (int k = 0; k < 3; k++) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = mem_word({a, k[1:0]});
      idle_cycles(1);
    end
    bus.mem_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== {a, 2'd3}) begin
      n_fail++;
      $display("FAIL mid_beat3: got req %b addr %h need 1 %h",
               bus.mem_req, bus.mem_addr, {a, 2'd3});
    end
    @(posedge clk);
    #1;
    bus.irq      = 1'b0;
    bus.ic_rw_en = 1'b0;
    rst          = 1'b1;
    idle_cycles(1);
    rst       = 1'b0;
    buf_vld_m = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.l2_busy, bus.l2_rdy, bus.complete, bus.rw_err, bus.mem_req} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_rst ctl: got %b need 00000",
               {bus.l2_busy, bus.l2_rdy, bus.complete, bus.rw_err, bus.mem_req});
    end
    n_chk++;
    if (bus.mem_addr !== 30'd0 || bus.data_wd_l2 !== 128'd0) begin
      n_fail++;
      $display("FAIL mid_rst data: got addr %h data %h need 0/0",
               bus.mem_addr, bus.data_wd_l2);
    end
    @(posedge clk);
    #1;
    do_txn(28'h0000123, 1'b0, "post_rst_old");
    do_txn(a, 1'b0, "post_rst_new");
    idle_cycles(1);
  endtask

  task automatic test_buffer();
    logic [27:0] b;
    b = 28'h0F00D00;
    for (int k = 0; k < 4; k++)
      wait_cfg[k] = $urandom_range(0, 2);
    do_txn(b, 1'b0, "buf_fill");
    idle_cycles(1);
    do_txn(b, 1'b0, "buf_repeat");
    bus.buf_inv = 1'b1;
    idle_cycles(1);
    bus.buf_inv = 1'b0;
    buf_vld_m   = 1'b0;
    do_txn(b, 1'b0, "buf_after_inv");
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++)
      wait_cfg[k] = $urandom_range(0, 1);
    do_txn(28'h0000A00, 1'b0, "b2b_0");
    do_txn(28'h0000A00, 1'b0, "b2b_1");
    do_txn(28'h0000B00, 1'b0, "b2b_2");
    idle_cycles(1);
  endtask

  task automatic test_random();
    logic [27:0] pool [4];
    for (int k = 0; k < 4; k++)
      pool[k] = 28'($urandom);
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < 4; k++)
        wait_cfg[k] = $urandom_range(0, 3);
      do_txn(pool[$urandom_range(0, 3)], ($urandom_range(0, 3) == 0),
             $sformatf("rnd%0d", i));
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_rw_err();
    test_reset_mid();
    test_buffer();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
